// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit - IF stage of the 5-stage pipeline.
// Holds the fetch PC, selects the next PC from the ID stage, and runs a
// req/ack handshake to a variable-latency instruction memory.
//
// Ports:
//   clock, resetn          clock (posedge) and asynchronous active-low reset
//   wpcir                  ID write-enable, 0 = stall (hold PC and instruction)
//   pcsource, bpc/rpc/jpc  next-PC select and the three redirect targets
//   imem_req/addr          instruction read request and its address (= pc)
//   imem_rdata/ack         returned word and completion strobe
//   pc, pc4                current fetch PC and pc+4
//   ins, ins_valid         instruction to the IF/ID register and its qualifier
//   ferr                   sticky misaligned-target error
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned redirect targets
// (sets ferr and halts fetch until reset). Without it, target bits [1:0] are
// cleared and ferr is tied low.
module pipe_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic        ferr
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
`endif

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] hold_r;       // word captured when ID stalls in the ack cycle
  logic [31:0] tgt_r;        // redirect target parked while a request drains
  logic [31:0] pc4_s;
  logic [31:0] target_raw_s;
  logic [31:0] target_s;
  logic        redir_s;

  assign pc4_s   = pc_r + 32'd4;
  assign redir_s = wpcir & (pcsource != 2'b00);

  // Next-PC target select from the ID stage
  always_comb begin
    target_raw_s = pc4_s;
    case (pcsource)
      2'b01:   target_raw_s = bpc;
      2'b10:   target_raw_s = rpc;
      2'b11:   target_raw_s = jpc;
      default: target_raw_s = pc4_s;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic ferr_r;
  logic trap_s;
  assign target_s = target_raw_s;
  assign trap_s   = redir_s & (target_raw_s[1:0] != 2'b00);
  assign ferr     = ferr_r;
`else
  // Misaligned targets are silently word-aligned.
  assign target_s = target_raw_s & 32'hFFFF_FFFC;
  assign ferr     = 1'b0;
`endif

  // Fetch state machine: PC, held word and parked redirect target
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      hold_r  <= 32'h0000_0000;
      tgt_r   <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
      ferr_r  <= 1'b0;
`endif
    end
`ifdef MISALIGN_TRAP_EN
    else if ((state_r != ST_HALT) && trap_s) begin
      // pc is left untouched so the faulting fetch address stays visible.
      ferr_r  <= 1'b1;
      state_r <= ST_HALT;
    end
`endif
    else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_ack) begin
            if (redir_s) begin
              pc_r <= target_s;
            end else if (wpcir) begin
              pc_r <= pc4_s;
            end else begin
              hold_r  <= imem_rdata;
              state_r <= ST_HOLD;
            end
          end else if (redir_s) begin
            // The request cannot be withdrawn; remember where to go after it.
            tgt_r   <= target_s;
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (redir_s) begin
            pc_r    <= target_s;
            state_r <= ST_FETCH;
          end else if (wpcir) begin
            pc_r    <= pc4_s;
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            // Newest redirect wins, even one arriving in the ack cycle.
            pc_r    <= redir_s ? target_s : tgt_r;
            state_r <= ST_FETCH;
          end else if (redir_s) begin
            tgt_r <= target_s;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
`ifdef MISALIGN_TRAP_EN
        ST_HALT: state_r <= ST_HALT;
`endif
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  // Memory request and instruction outputs decoded from state
  always_comb begin
    imem_req  = 1'b0;
    ins       = NOP_INS;
    ins_valid = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ins       = imem_rdata;
          ins_valid = 1'b1;
        end else begin
          ins       = NOP_INS;
          ins_valid = 1'b0;
        end
      end
      ST_HOLD: begin
        imem_req  = 1'b0;
        ins       = hold_r;
        ins_valid = 1'b1;
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        ins       = NOP_INS;
        ins_valid = 1'b0;
      end
      default: begin
        imem_req  = 1'b0;
        ins       = NOP_INS;
        ins_valid = 1'b0;
      end
    endcase
  end

  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign pc4       = pc4_s;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Self-checking bench for pipe_fetch_unit: a directed vector table for the
// fetch/stall/drain/redirect scenarios, then randomized stimulus checked
// against a flag-based behavioural model of the fetch stage.
module tb_pipe_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOPW   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        resetn;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc, pc4, ins;
  logic        ins_valid;
  logic        ferr;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_fetch_unit #(.RESET_PC(RST_PC), .NOP_INS(NOPW)) dut (
    .clock(clock), .resetn(resetn), .wpcir(wpcir), .pcsource(pcsource),
    .bpc(bpc), .rpc(rpc), .jpc(jpc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .pc(pc), .pc4(pc4), .ins(ins), .ins_valid(ins_valid), .ferr(ferr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        w;
    logic [1:0]  ps;
    logic [31:0] tg;
    logic        ack;
    logic [31:0] rd;
    logic [31:0] addr;
    logic        req;
    logic        cv;    // compare ins/ins_valid in this row
    logic [31:0] ins;
    logic        v;
    logic        fe;
  } vec_t;

  vec_t vt[25];

  function automatic vec_t mk(input logic w, input logic [1:0] ps, input logic [31:0] tg,
                              input logic ack, input logic [31:0] rd, input logic [31:0] addr,
                              input logic req, input logic cv, input logic [31:0] i,
                              input logic v, input logic fe);
    vec_t r;
    r.w = w; r.ps = ps; r.tg = tg; r.ack = ack; r.rd = rd; r.addr = addr;
    r.req = req; r.cv = cv; r.ins = i; r.v = v; r.fe = fe;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Selected target goes on the chosen bus, unrelated junk on the other two.
  task automatic drive(input logic w, input logic [1:0] ps, input logic [31:0] tg,
                       input logic ack, input logic [31:0] rd);
    wpcir      = w;
    pcsource   = ps;
    bpc        = (ps == 2'b01) ? tg : $urandom;
    rpc        = (ps == 2'b10) ? tg : $urandom;
    jpc        = (ps == 2'b11) ? tg : $urandom;
    imem_ack   = ack;
    imem_rdata = rd;
  endtask

  // Behavioural model state
  logic [31:0] m_pc, m_hword, m_dtgt;
  logic        m_held, m_drain, m_halt;

  initial begin
    logic [31:0] e_ins, t;
    logic        e_req, e_v, redir;

    // ---------------- directed table ----------------
    vt[0]  = mk(1'b1, 2'b00, 32'h0,     1'b1, 32'hA000_0000, 32'h000, 1'b1, 1'b1, 32'hA000_0000, 1'b1, 1'b0);
    vt[1]  = mk(1'b1, 2'b00, 32'h0,     1'b1, 32'hA000_0001, 32'h004, 1'b1, 1'b1, 32'hA000_0001, 1'b1, 1'b0);
    vt[2]  = mk(1'b1, 2'b00, 32'h0,     1'b1, 32'hA000_0002, 32'h008, 1'b1, 1'b1, 32'hA000_0002, 1'b1, 1'b0);
    vt[3]  = mk(1'b1, 2'b00, 32'h0,     1'b1, 32'hA000_0003, 32'h00C, 1'b1, 1'b1, 32'hA000_0003, 1'b1, 1'b0);
    vt[4]  = mk(1'b1, 2'b00, 32'h0,     1'b0, 32'h1111_1111, 32'h010, 1'b1, 1'b1, NOPW,          1'b0, 1'b0);
    vt[5]  = mk(1'b1, 2'b00, 32'h0,     1'b0, 32'h2222_2222, 32'h010, 1'b1, 1'b1, NOPW,          1'b0, 1'b0);
    vt[6]  = mk(1'b1, 2'b00, 32'h0,     1'b1, 32'hB000_0000, 32'h010, 1'b1, 1'b1, 32'hB000_0000, 1'b1, 1'b0);
    vt[7]  = mk(1'b1, 2'b11, 32'h20,    1'b1, 32'hB000_0001, 32'h014, 1'b1, 1'b0, NOPW,          1'b0, 1'b0);
    vt[8]  = mk(1'b0, 2'b00, 32'h0,     1'b1, 32'hC000_0000, 32'h020, 1'b1, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    vt[9]  = mk(1'b0, 2'b00, 32'h0,     1'b0, 32'h3333_3333, 32'h020, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    vt[10] = mk(1'b0, 2'b11, 32'h500,   1'b1, 32'hDEAD_BEEF, 32'h020, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    vt[11] = mk(1'b0, 2'b00, 32'h0,     1'b0, 32'h4444_4444, 32'h020, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    vt[12] = mk(1'b1, 2'b00, 32'h0,     1'b0, 32'h5555_5555, 32'h020, 1'b0, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
    vt[13] = mk(1'b1, 2'b11, 32'h40,    1'b1, 32'hC000_0001, 32'h024, 1'b1, 1'b0, NOPW,          1'b0, 1'b0);
    vt[14] = mk(1'b1, 2'b11, 32'h180,   1'b0, 32'h6666_6666, 32'h040, 1'b1, 1'b1, NOPW,          1'b0, 1'b0);
    vt[15] = mk(1'b1, 2'b11, 32'h100,   1'b0, 32'h7777_7777, 32'h040, 1'b1, 1'b1, NOPW,          1'b0, 1'b0);
    vt[16] = mk(1'b1, 2'b00, 32'h0,     1'b0, 32'h8888_8888, 32'h040, 1'b1, 1'b1, NOPW,          1'b0, 1'b0);
    vt[17] = mk(1'b1, 2'b00, 32'h0,     1'b1, 32'hD000_0000, 32'h040, 1'b1, 1'b1, NOPW,          1'b0, 1'b0);
    vt[18] = mk(1'b1, 2'b01, 32'h200,   1'b1, 32'hD000_0001, 32'h100, 1'b1, 1'b0, NOPW,          1'b0, 1'b0);
    vt[19] = mk(1'b0, 2'b00, 32'h0,     1'b1, 32'hD000_0002, 32'h200, 1'b1, 1'b1, 32'hD000_0002, 1'b1, 1'b0);
    vt[20] = mk(1'b1, 2'b10, 32'h300,   1'b0, 32'h9999_9999, 32'h200, 1'b0, 1'b1, 32'hD000_0002, 1'b1, 1'b0);
    vt[21] = mk(1'b1, 2'b00, 32'h0,     1'b1, 32'hE000_0000, 32'h300, 1'b1, 1'b1, 32'hE000_0000, 1'b1, 1'b0);
    vt[22] = mk(1'b1, 2'b10, 32'h302,   1'b1, 32'hE000_0001, 32'h304, 1'b1, 1'b0, NOPW,          1'b0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    vt[23] = mk(1'b1, 2'b00, 32'h0,     1'b0, 32'hAAAA_AAAA, 32'h304, 1'b0, 1'b1, NOPW,          1'b0, 1'b1);
    vt[24] = mk(1'b1, 2'b11, 32'h400,   1'b1, 32'hF000_0000, 32'h304, 1'b0, 1'b1, NOPW,          1'b0, 1'b1);
`else
    vt[23] = mk(1'b1, 2'b00, 32'h0,     1'b0, 32'hAAAA_AAAA, 32'h300, 1'b1, 1'b1, NOPW,          1'b0, 1'b0);
    vt[24] = mk(1'b1, 2'b11, 32'h400,   1'b1, 32'hF000_0000, 32'h300, 1'b1, 1'b0, NOPW,          1'b0, 1'b0);
`endif

    // ---------------- reset ----------------
    resetn = 1'b0;
    drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
    #12;
    chk("reset_pc", pc, RST_PC);
    chk("reset_req", {31'd0, imem_req}, 32'd1);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_valid", {31'd0, ins_valid}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      drive(vt[i].w, vt[i].ps, vt[i].tg, vt[i].ack, vt[i].rd);
      #1;
      chk($sformatf("row%0d_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("row%0d_pc", i), pc, vt[i].addr);
      chk($sformatf("row%0d_pc4", i), pc4, vt[i].addr + 32'd4);
      chk($sformatf("row%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].req});
      chk($sformatf("row%0d_ferr", i), {31'd0, ferr}, {31'd0, vt[i].fe});
      if (vt[i].cv) begin
        chk($sformatf("row%0d_ins", i), ins, vt[i].ins);
        chk($sformatf("row%0d_valid", i), {31'd0, ins_valid}, {31'd0, vt[i].v});
      end
    end

    // After the misaligned redirect: halted, or word-aligned jump taken.
    @(negedge clock);
    drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0);
    #1;
`ifdef MISALIGN_TRAP_EN
    chk("halt_addr", imem_addr, 32'h304);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_ferr", {31'd0, ferr}, 32'd1);
`else
    chk("jmp_addr", imem_addr, 32'h400);
    chk("jmp_req", {31'd0, imem_req}, 32'd1);
    chk("jmp_ferr", {31'd0, ferr}, 32'd0);
`endif

    // Asynchronous reset pulse mid-cycle
    resetn = 1'b0;
    #1;
    chk("rst2_pc", pc, RST_PC);
    chk("rst2_ferr", {31'd0, ferr}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    chk("rst2_addr", imem_addr, RST_PC);
    chk("rst2_req", {31'd0, imem_req}, 32'd1);

    // ---------------- randomized vs model ----------------
    m_pc = RST_PC; m_hword = 32'h0; m_dtgt = 32'h0;
    m_held = 1'b0; m_drain = 1'b0; m_halt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      wpcir      = ($urandom_range(3) != 0);
      pcsource   = 2'($urandom_range(3));
`ifdef MISALIGN_TRAP_EN
      bpc = $urandom & 32'hFFFF_FFFC;
      rpc = $urandom & 32'hFFFF_FFFC;
      jpc = $urandom & 32'hFFFF_FFFC;
`else
      bpc = $urandom; rpc = $urandom; jpc = $urandom;
`endif
      imem_ack   = 1'($urandom_range(1));
      imem_rdata = $urandom;
      redir = wpcir && (pcsource != 2'b00);

      if (m_halt)       begin e_req = 1'b0; e_ins = NOPW;    e_v = 1'b0; end
      else if (m_held)  begin e_req = 1'b0; e_ins = m_hword; e_v = 1'b1; end
      else if (m_drain) begin e_req = 1'b1; e_ins = NOPW;    e_v = 1'b0; end
      else begin
        e_req = 1'b1;
        e_ins = imem_ack ? imem_rdata : NOPW;
        e_v   = imem_ack;
      end
      #1;
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_pc4", pc4, m_pc + 32'd4);
      chk("rnd_req", {31'd0, imem_req}, {31'd0, e_req});
      chk("rnd_ins", ins, e_ins);
      chk("rnd_valid", {31'd0, ins_valid}, {31'd0, e_v});
      chk("rnd_ferr", {31'd0, ferr}, {31'd0, m_halt});

      @(posedge clock);
      case (pcsource)
        2'b01:   t = bpc;
        2'b10:   t = rpc;
        default: t = jpc;
      endcase
`ifdef MISALIGN_TRAP_EN
      if (!m_halt && redir && (t % 4 != 0)) m_halt = 1'b1;
`else
      t = t - (t % 4);
`endif
      if (m_halt) begin
        // frozen until reset
      end else if (m_held) begin
        if (redir)      begin m_pc = t;          m_held = 1'b0; end
        else if (wpcir) begin m_pc = m_pc + 4;   m_held = 1'b0; end
      end else if (m_drain) begin
        if (redir) m_dtgt = t;
        if (imem_ack) begin m_pc = m_dtgt; m_drain = 1'b0; end
      end else if (imem_ack) begin
        if (redir)      m_pc = t;
        else if (wpcir) m_pc = m_pc + 4;
        else begin m_held = 1'b1; m_hword = imem_rdata; end
      end else if (redir) begin
        m_drain = 1'b1;
        m_dtgt  = t;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
